// File: rtl/envelope_generator.sv
// rtl/envelope_generator.sv - Envelope level generator: prescaler, period counter and shape state machine
module envelope_generator #(
  parameter int PERIOD_BITS    = 16,
  parameter int PRESCALER_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [PERIOD_BITS-1:0] period,
  input  logic                   continue_,
  input  logic                   attack,
  input  logic                   alternate,
  input  logic                   hold,
  output logic [3:0]             envelope,
  output logic                   holding
);

  typedef enum logic {RUN, HOLD} state_t;

  state_t                    state;
  logic [PRESCALER_BITS-1:0] prescaler;
  logic [PERIOD_BITS-1:0]    count;
  logic [PERIOD_BITS-1:0]    period_m1;
  logic [3:0]                step;
  logic                      invert;
  logic                      tick;
  logic                      step_strobe;

  // Period 0 behaves as period 1. The >= compare makes a lowered period
  // step on the next tick instead of wrapping through the full counter range.
  assign period_m1   = (period == '0) ? '0 : period - PERIOD_BITS'(1);
  assign tick        = &prescaler;
  assign step_strobe = tick && (count >= period_m1);

  assign envelope = step ^ {4{invert}};
  assign holding  = (state == HOLD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      count     <= '0;
      step      <= 4'd0;
      invert    <= 1'b0;
      state     <= HOLD;
    end else if (restart) begin
      // Restart wins over any step strobe in the same cycle.
      prescaler <= '0;
      count     <= '0;
      step      <= 4'd0;
      invert    <= ~attack;
      state     <= RUN;
    end else begin
      prescaler <= prescaler + PRESCALER_BITS'(1);
      if (tick) begin
        count <= step_strobe ? '0 : count + PERIOD_BITS'(1);
      end
      if (step_strobe && state == RUN) begin
        if (step != 4'd15) begin
          step <= step + 4'd1;
        end else if (!continue_) begin
          state  <= HOLD;
          step   <= 4'd0;
          invert <= 1'b0;
        end else if (hold) begin
          state <= HOLD;
          if (alternate) invert <= ~invert;
        end else begin
          step <= 4'd0;
          if (alternate) invert <= ~invert;
        end
      end
    end
  end

endmodule

// File: doc/envelope_generator.md
ENVELOPE_GENERATOR -- requirements
Module: envelope_generator

Interface
REQ-001 SHALL have parameter PERIOD_BITS, default 16, width of the envelope period input and period counter.
REQ-002 SHALL have parameter PRESCALER_BITS, default 4; one prescaler tick every 2^PRESCALER_BITS clk cycles.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-005 SHALL have port restart, input, 1, one-cycle synchronous pulse issued by the register file on any write to R13.
REQ-006 SHALL have port period, input, PERIOD_BITS, envelope period {R12,R11}.
REQ-007 SHALL have ports continue_, attack, alternate, hold, input, 1 each, shape bits R13[3:0].
REQ-008 SHALL have port envelope, output, 4, level consumed by the channel attenuators when the amplitude bit-4 (envelope select) is set.
REQ-009 SHALL have port holding, output, 1, high while the generator is in HOLD.

Function
REQ-010 SHALL contain a PRESCALER_BITS-wide prescaler incrementing every cycle with wrap; tick asserted in a cycle when prescaler is all-ones.
REQ-011 SHALL contain a PERIOD_BITS-wide period counter; on tick: if counter >= period-1 then counter <= 0 and step strobe asserted, else counter+1.
REQ-012 SHALL treat period 0 identically to period 1 (step on every tick).
REQ-013 SHALL, when period is lowered below the current count mid-run, produce a step on the next tick (>= compare, no wrap through 2^PERIOD_BITS).
REQ-014 SHALL have two states: RUN and HOLD; holding = (state == HOLD).
REQ-015 SHALL hold a 4-bit step counter and an invert flag; envelope = step XOR {4{invert}}, driven only from registers.
REQ-016 SHALL in RUN, on step strobe with step < 15, increment step.
REQ-017 SHALL in RUN, on step strobe with step == 15 and continue_=0: enter HOLD, force step=0 and invert=0 (envelope=0).
REQ-018 SHALL in RUN, on step strobe with step == 15, continue_=1, hold=1: enter HOLD, keep step=15, toggle invert iff alternate=1.
REQ-019 SHALL in RUN, on step strobe with step == 15, continue_=1, hold=0: wrap step to 0, toggle invert iff alternate=1, remain RUN.
REQ-020 SHALL in HOLD ignore step strobes; prescaler and period counter keep running.
REQ-021 SHALL on restart: prescaler=0, period counter=0, step=0, invert=~attack (current input), state=RUN, in the following cycle.
REQ-022 SHALL give restart priority over a tick/step occurring in the same cycle (that step is discarded).
REQ-023 SHALL sample shape inputs only at restart (attack) and at end of cycle (continue_, hold, alternate); changes without restart take effect at next end of cycle.
REQ-024 SHALL after restart produce first step strobe at clk edge 2^PRESCALER_BITS * max(period,1) counting from the restart edge.

Reset
REQ-025 SHALL on reset assertion, immediately and asynchronously: prescaler=0, period counter=0, step=0, invert=0, state=HOLD; hence envelope=0, holding=1.
REQ-026 SHALL remain in HOLD with envelope=0 after reset release until the first restart pulse.
REQ-027 SHALL abort any cycle in progress when reset asserts mid-operation, with no residual state.

Verification
REQ-028 Shape 1101 (C,At,Alt,H), period=1, restart -> envelope 0,1,...,15 changing every 16 clk, then holds 15, holding=1.
REQ-029 Shape 1000, period=2, restart -> envelope 15,14,...,0 each 32 clk, then 15 again (sawtooth), holding stays 0.
REQ-030 Shape 1110, period=1 -> 0..15 then 15..0 then 0..15 (triangle), each level 16 clk; shape 1011 -> 15..0 then hold 15.
REQ-031 Shape 0100 and 0000, period=0 -> up (resp. down) ramp with 16 clk steps, then envelope=0, holding=1; period=0 timing equals period=1.
REQ-032 Restart asserted mid-ramp at envelope=7 coincident with a step strobe -> next cycle envelope=0 (attack=1) or 15 (attack=0), first new step 16*period clk later.
REQ-033 Reset asserted asynchronously mid-ramp -> envelope=0 and holding=1 before next clk edge; no change until restart.
